// File: rtl/sgd_mem_rd_cmd_gen.sv
// Splits one dataset read job into boundary-aligned axis_mem_cmd bursts, issuing
// each burst only when the downstream A FIFO has credit for every line it returns.
module sgd_mem_rd_cmd_gen #(
  parameter int unsigned CL_BYTES        = 64,
  parameter int unsigned MAX_BURST_BYTES = 4096,
  parameter int unsigned CREDIT_CL       = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic [31:0] total_bytes,
  output logic        busy,
  output logic        done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_address,
  output logic [31:0] cmd_length,
  input  logic        cl_consumed,
  output logic        credit_err
);

  localparam int unsigned ClShift    = $clog2(CL_BYTES);
  localparam int unsigned BurstShift = $clog2(MAX_BURST_BYTES);
  localparam int unsigned RoomW      = BurstShift + 1;
  localparam int unsigned CreditW    = $clog2(CREDIT_CL) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDone} state_e;

  state_e              state_q, state_d;
  logic [63:0]         cur_addr_q, cur_addr_d;
  logic [32:0]         rem_q, rem_d;
  logic [63:0]         cmd_address_q, cmd_address_d;
  logic [31:0]         cmd_length_q, cmd_length_d;
  logic [CreditW-1:0]  credits_q, credits_d;
  logic                credit_err_q, credit_err_d;

  logic [32:0]         rem_round;
  logic [RoomW-1:0]    room;
  logic [32:0]         burst_len;
  logic [31:0]         len_cl;
  logic                credit_ok;
  logic                cmd_fire;
  logic [CreditW-1:0]  take;
  logic [CreditW-1:0]  after_take;

  logic unused_bits;
  assign unused_bits = ^{base_addr[ClShift-1:0], rem_round[ClShift-1:0], burst_len[32]};

  // 33 bits so that rounding a near-4GiB length up cannot overflow.
  assign rem_round = {1'b0, total_bytes} + 33'(CL_BYTES - 1);
  assign room      = RoomW'(MAX_BURST_BYTES) - {1'b0, cur_addr_q[BurstShift-1:0]};
  assign burst_len = (rem_q < 33'(room)) ? rem_q : 33'(room);
  assign len_cl    = cmd_length_q >> ClShift;
  assign credit_ok = (32'(credits_q) >= len_cl);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_q    <= '0;
      rem_q         <= '0;
      cmd_address_q <= '0;
      cmd_length_q  <= '0;
      credits_q     <= CreditW'(CREDIT_CL);
      credit_err_q  <= 1'b0;
    end else begin
      cur_addr_q    <= cur_addr_d;
      rem_q         <= rem_d;
      cmd_address_q <= cmd_address_d;
      cmd_length_q  <= cmd_length_d;
      credits_q     <= credits_d;
      credit_err_q  <= credit_err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_d         = rem_q;
    cmd_address_d = cmd_address_q;
    cmd_length_d  = cmd_length_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d = {base_addr[63:ClShift], {ClShift{1'b0}}};
          rem_d      = {rem_round[32:ClShift], {ClShift{1'b0}}};
          state_d    = StCalc;
        end
      end
      StCalc: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          cmd_address_d = cur_addr_q;
          cmd_length_d  = burst_len[31:0];
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (cmd_fire) begin
          cur_addr_d = cur_addr_q + 64'(cmd_length_q);
          rem_d      = rem_q - 33'(cmd_length_q);
          state_d    = (rem_d == '0) ? StDone : StCalc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Credits: a burst never returns zero lines, so overflow is only possible with no handshake.
  always_comb begin
    take         = cmd_fire ? CreditW'(len_cl) : '0;
    after_take   = credits_q - take;
    credits_d    = after_take;
    credit_err_d = credit_err_q;
    if (cl_consumed) begin
      if (after_take >= CreditW'(CREDIT_CL)) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = after_take + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q == StCalc) || (state_q == StIssue);
    done        = (state_q == StDone);
    cmd_valid   = (state_q == StIssue) && credit_ok;
    cmd_address = cmd_address_q;
    cmd_length  = cmd_length_q;
    credit_err  = credit_err_q;
  end

endmodule

// File: tb/tb_sgd_mem_rd_cmd_gen.sv
// Directed bench for sgd_mem_rd_cmd_gen; issued commands are scored against a queue of
// bursts pushed when each job is started.
module tb_sgd_mem_rd_cmd_gen;

  logic        clk;
  logic        rst;
  logic [63:0] base_addr;
  logic [31:0] total_bytes;

  logic        start, busy, done, cmd_valid, cmd_ready, cl_consumed, credit_err;
  logic [63:0] cmd_address;
  logic [31:0] cmd_length;

  logic        s_start, s_busy, s_done, s_cmd_valid, s_cmd_ready, s_cl_consumed, s_credit_err;
  logic [63:0] s_cmd_address;
  logic [31:0] s_cmd_length;

  int passes = 0;
  int checks = 0;
  logic [95:0] exp_q[$];
  logic [95:0] s_exp_q[$];

  sgd_mem_rd_cmd_gen dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_bytes(total_bytes),
    .busy(busy), .done(done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_address(cmd_address), .cmd_length(cmd_length), .cl_consumed(cl_consumed),
    .credit_err(credit_err)
  );

  sgd_mem_rd_cmd_gen #(.CREDIT_CL(64)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .base_addr(base_addr), .total_bytes(total_bytes),
    .busy(s_busy), .done(s_done), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_address(s_cmd_address), .cmd_length(s_cmd_length), .cl_consumed(s_cl_consumed),
    .credit_err(s_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        cyc = i;
        return;
      end
    end
  endtask

  // Scoreboards: every accepted command must match the next expected burst.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", cmd_address, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("cmd_address", cmd_address, e[95:32]);
        chk("cmd_length", 64'(cmd_length), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_cmd_valid && s_cmd_ready) begin
      if (s_exp_q.size() == 0) begin
        chk("s_unexpected_cmd", s_cmd_address, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = s_exp_q.pop_front();
        chk("s_cmd_address", s_cmd_address, e[95:32]);
        chk("s_cmd_length", 64'(s_cmd_length), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_bytes = '0;
    cmd_ready = 1'b0; cl_consumed = 1'b0;
    s_start = 1'b0; s_cmd_ready = 1'b0; s_cl_consumed = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_address", cmd_address, 0);
    chk("rst_cmd_length", 64'(cmd_length), 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_credits", 64'(dut.credits_q), 2048);

    // Aligned two-burst job
    step();
    cmd_ready = 1'b1;
    start = 1'b1; base_addr = 64'h1000; total_bytes = 32'h2000;
    exp_q.push_back({64'h1000, 32'd4096});
    exp_q.push_back({64'h2000, 32'd4096});
    @(negedge clk);
    chk("t1_busy_t0", busy, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t1_busy_t1", busy, 1);
    chk("t1_valid_t1", cmd_valid, 0);
    @(negedge clk);
    chk("t1_valid_t2", cmd_valid, 1);
    wait_done(50, cyc);
    chk("t1_done_latency", 64'(cyc), 2);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_credits", 64'(dut.credits_q), 1920);
    chk("t1_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Unaligned base, boundary split and length rounding
    step();
    start = 1'b1; base_addr = 64'h0FD3; total_bytes = 32'd100;
    exp_q.push_back({64'h0FC0, 32'd64});
    exp_q.push_back({64'h1000, 32'd64});
    step();
    start = 1'b0;
    wait_done(50, cyc);
    chk("t2_done_seen", 64'(cyc >= 0), 1);
    chk("t2_queue_empty", 64'(exp_q.size()), 0);
    chk("t2_credits", 64'(dut.credits_q), 1918);

    // Backpressure, then handshake coinciding with a credit return
    step();
    cmd_ready = 1'b0;
    start = 1'b1; base_addr = 64'h20000; total_bytes = 32'd4096;
    exp_q.push_back({64'h20000, 32'd4096});
    step();
    start = 1'b0;
    wait_valid(20, cyc);
    chk("t4_valid_seen", 64'(cyc >= 0), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("t4_hold_valid", cmd_valid, 1);
      chk("t4_hold_addr", cmd_address, 64'h20000);
      chk("t4_hold_len", 64'(cmd_length), 4096);
    end
    step();
    cmd_ready = 1'b1; cl_consumed = 1'b1;
    step();
    cmd_ready = 1'b0; cl_consumed = 1'b0;
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_credits", 64'(dut.credits_q), 1855);
    chk("t4_queue_empty", 64'(exp_q.size()), 0);

    // Zero-length job
    step();
    start = 1'b1; base_addr = 64'h3000; total_bytes = 32'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t5_zero_busy", busy, 1);
    chk("t5_zero_valid_t1", cmd_valid, 0);
    chk("t5_zero_done_t1", done, 0);
    @(negedge clk);
    chk("t5_zero_done_t2", done, 1);
    chk("t5_zero_valid_t2", cmd_valid, 0);

    // Starts while busy and in the done cycle are ignored
    step();
    cmd_ready = 1'b1;
    start = 1'b1; base_addr = 64'h40000; total_bytes = 32'd8192;
    exp_q.push_back({64'h40000, 32'd4096});
    exp_q.push_back({64'h41000, 32'd4096});
    step();
    start = 1'b0;
    step();
    start = 1'b1; base_addr = 64'h80000; total_bytes = 32'd64;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    @(negedge clk);
    chk("t5_done_cycle", done, 1);
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_idle_valid", cmd_valid, 0);
      chk("t5_idle_busy", busy, 0);
    end
    chk("t5_queue_empty", 64'(exp_q.size()), 0);
    chk("t5_credits", 64'(dut.credits_q), 1727);

    // Reset in the middle of an issue, then credit overflow
    step();
    cmd_ready = 1'b0;
    start = 1'b1; base_addr = 64'h100000; total_bytes = 32'd4096;
    step();
    start = 1'b0;
    wait_valid(20, cyc);
    chk("t6_valid_seen", 64'(cyc >= 0), 1);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_addr", cmd_address, 0);
    chk("t6_rst_len", 64'(cmd_length), 0);
    chk("t6_rst_credits", 64'(dut.credits_q), 2048);
    step();
    rst = 1'b0;
    step();
    cl_consumed = 1'b1;
    step();
    cl_consumed = 1'b0;
    @(negedge clk);
    chk("t6_credit_err", credit_err, 1);
    chk("t6_credits_sat", 64'(dut.credits_q), 2048);

    // Credit stall with a 64-line FIFO
    step();
    chk("t3_credits_init", 64'(dut_s.credits_q), 64);
    s_cmd_ready = 1'b1;
    s_start = 1'b1; base_addr = 64'h0; total_bytes = 32'd8192;
    s_exp_q.push_back({64'h0, 32'd4096});
    s_exp_q.push_back({64'h1000, 32'd4096});
    step();
    s_start = 1'b0;
    step();
    step();
    chk("t3_credits_drained", 64'(dut_s.credits_q), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_stall_valid", s_cmd_valid, 0);
      step();
    end
    for (int k = 0; k < 64; k++) begin
      s_cl_consumed = 1'b1;
      @(negedge clk);
      chk("t3_return_valid", s_cmd_valid, 0);
      step();
    end
    s_cl_consumed = 1'b0;
    @(negedge clk);
    chk("t3_reissue_valid", s_cmd_valid, 1);
    @(negedge clk);
    chk("t3_done", s_done, 1);
    chk("t3_queue_empty", 64'(s_exp_q.size()), 0);
    chk("t3_credits_end", 64'(dut_s.credits_q), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sgd_mem_rd_cmd_gen.md
Name: sgd_mem_rd_cmd_gen

Overview:
- Issues the training-dataset read commands, tagged MEM_RD_A_TAG by the shell, that fill the A FIFO of the SGD engines.
- Takes one job (base address, byte length) and splits it into axis_mem_cmd bursts that never cross a MAX_BURST_BYTES-aligned boundary.
- Flow control is credit-based: a burst is issued only when the downstream A FIFO (2^A_FIFO_DEPTH_BITS cache lines) has room for every cache line it will return.

Parameters:
- CL_BYTES, 64: bytes per cache line (NUM_BITS_PER_CL/8).
- MAX_BURST_BYTES, 4096: maximum burst size and its alignment boundary; power of two, multiple of CL_BYTES.
- CREDIT_CL, 2048: initial and maximum credit in cache lines (2^A_FIFO_DEPTH_BITS).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle job request; ignored while busy=1.
- base_addr, in, 64: job byte address, sampled on start; bits [5:0] are treated as zero.
- total_bytes, in, 32: job length in bytes, sampled on start; rounded up to a multiple of CL_BYTES.
- busy, out, 1: high from the cycle after an accepted start until the done cycle.
- done, out, 1: one-cycle pulse when the last command is accepted.
- cmd_valid, out, 1: axis_mem_cmd master valid.
- cmd_ready, in, 1: axis_mem_cmd master ready.
- cmd_address, out, 64: burst byte address.
- cmd_length, out, 32: burst length in bytes, a multiple of CL_BYTES.
- cl_consumed, in, 1: downstream popped one cache line from the A FIFO; returns one credit.
- credit_err, out, 1: sticky flag, set when a credit return would exceed CREDIT_CL.

Behaviour:
- Reset values: busy=0, done=0, cmd_valid=0, cmd_address=0, cmd_length=0, credit_err=0, credits=CREDIT_CL, state=IDLE.
- Credit counter:
  - Width is clog2(CREDIT_CL)+1.
  - On a command handshake, subtract cmd_length/CL_BYTES.
  - On cl_consumed, add 1.
  - When both occur in the same cycle, apply both: net change = 1 - cmd_length/CL_BYTES.
  - A return that would make credits exceed CREDIT_CL is dropped and sets credit_err.
- IDLE:
  - On start, latch cur_addr = {base_addr[63:6], 6'b0} and rem = roundup(total_bytes, CL_BYTES).
  - Go to CALC; busy=1 from the next cycle.
- CALC (1 cycle):
  - If rem==0, go to DONE.
  - Otherwise burst = min(rem, MAX_BURST_BYTES - (cur_addr mod MAX_BURST_BYTES)).
  - Register cmd_address=cur_addr and cmd_length=burst, then go to ISSUE.
- ISSUE:
  - cmd_valid=1 only while credits >= cmd_length/CL_BYTES.
  - Credit is evaluated from the registered counter value. cl_consumed arriving in the same cycle takes effect on the next cycle.
  - Once cmd_valid is high, it stays high and address/length stay stable until cmd_ready. A credit check already passed cannot be revoked, because credits only decrease on this block's own handshake.
  - On handshake: cur_addr += burst, rem -= burst. If the new rem is 0, go to DONE; otherwise go to CALC.
- DONE (1 cycle): done=1, busy=0 in the same cycle, then go to IDLE. A start in the DONE cycle is ignored.
- Latency:
  - start at cycle t gives first cmd_valid at t+2, given sufficient credit.
  - Back-to-back bursts are separated by one CALC cycle, so at most one command every 2 cycles.
- total_bytes=0: no command is issued; done pulses at t+2.
- Address arithmetic is 64-bit and wraps modulo 2^64 without any flag.
- Reset mid-job:
  - Immediately returns to IDLE, clears cmd_valid and restores credits to CREDIT_CL.
  - The downstream FIFO must be reset together with this block.

Test Plan:
- Aligned job: base 0x1000, total 0x2000 -> two commands (0x1000, 4096) and (0x2000, 4096), done one cycle after the second handshake; credits end at 2048-128=1920.
- Unaligned boundary plus rounding: base 0x0FC0, total 100 -> rounded to 128; bursts (0x0FC0, 64) and (0x1000, 64).
- Credit stall:
  - Set CREDIT_CL=64; run base 0, total 8192.
  - First burst (0, 4096) is issued; cmd_valid stays low until 64 cl_consumed pulses arrive.
  - Second burst (0x1000, 4096) is issued 1 cycle after the credit becomes visible.
- Backpressure plus simultaneous credit: hold cmd_ready=0 for 5 cycles -> address/length stable; handshake while cl_consumed=1 -> credits change by 1-64=-63.
- Zero length and busy start: total 0 -> no cmd_valid, done at t+2. A second start during a busy job is ignored, with no extra commands.
- Reset mid-issue plus overflow: rst while cmd_valid=1 -> all outputs return to reset values. cl_consumed with credits=CREDIT_CL -> credit_err=1, credits unchanged.
